fmul_arbiter: RTL and testbench
===============================

FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have derived localparam IDX_W, $clog2(NUM_REQ), requester index width.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid_i  input  NUM_REQ  per-requester multiply request.
REQ-006 SHALL have port req_a_i  input  NUM_REQ x 32  per-requester IEEE-754 single operand A.
REQ-007 SHALL have port req_b_i  input  NUM_REQ x 32  per-requester operand B.
REQ-008 SHALL have port req_ready_o  output  NUM_REQ  one-hot accept; transfer = valid & ready.
REQ-009 SHALL have port resp_valid_o  output  NUM_REQ  one-hot, one-cycle result pulse.
REQ-010 SHALL have port resp_z_o  output  32  product for the pulsed requester.
REQ-011 SHALL have port busy_o  output  1  high whenever not IDLE.
REQ-012 SHALL have ports mul_a_o / mul_b_o  output  32 each  operands to the shared multiplier.
REQ-013 SHALL have port mul_exec_strobe_o  output  1  start pulse to the multiplier.
REQ-014 SHALL have ports mul_z_i  input  32 and mul_done_strobe_i  input  1  multiplier result and completion pulse.

Function
REQ-015 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> IDLE.
REQ-016 IDLE: req_ready_o SHALL be combinational, equal to the round-robin grant of req_valid_i; all zero outside IDLE.
REQ-017 Round-robin: search SHALL start at (last_grant+1) mod NUM_REQ and take the first asserted valid.
REQ-018 On a transfer, SHALL register operands into mul_a_o/mul_b_o, the index into cur_idx and last_grant, and go to ISSUE.
REQ-019 ISSUE: mul_exec_strobe_o SHALL be high for exactly this one cycle, then go to WAIT.
REQ-020 mul_a_o/mul_b_o SHALL remain stable from ISSUE until mul_done_strobe_i is seen; the multiplier samples them the cycle after the strobe.
REQ-021 WAIT: on mul_done_strobe_i, SHALL register mul_z_i into resp_z_o, pulse resp_valid_o[cur_idx] for one cycle, and go to IDLE.
REQ-022 resp_z_o SHALL hold its value until the next response.
REQ-023 mul_done_strobe_i in IDLE or ISSUE SHALL be ignored.
REQ-024 A new grant SHALL NOT be made in the cycle resp_valid_o pulses; earliest re-grant is the next cycle (one outstanding operation).
REQ-025 Latency SHALL be: transfer edge +1 strobe, done edge +1 resp pulse.
REQ-026 A requester deasserting valid before ready SHALL simply lose arbitration; there is no stored request state.
REQ-027 Requests arriving while busy SHALL wait; no queueing.

Reset
REQ-028 Reset SHALL force state IDLE, req_ready_o/resp_valid_o/mul_exec_strobe_o/busy_o to 0, and resp_z_o/mul_a_o/mul_b_o to 0.
REQ-029 Reset SHALL set last_grant to NUM_REQ-1 so requester 0 has first priority.
REQ-030 Reset mid-operation SHALL abandon the operation with no response pulse; the multiplier shares reset_i.
REQ-031 If reset_i and a transfer coincide, reset SHALL win.

Structure
REQ-032 fpu_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT) and the FP32 width constant.
REQ-033 Round-robin selection SHALL live in one sub-module, rr_arbiter (inputs: request vector, last_grant; output: one-hot grant).
REQ-034 The multiplier SHALL be instantiated outside this block and connected by the mul_* ports.

Verification
REQ-035 Scenario: req0 only, a=0x40000000, b=0x40400000 -> one ready pulse, strobe next cycle, resp_valid_o=0001, resp_z_o=0x40C00000.
REQ-036 Scenario: req0 and req2 valid together after reset -> req0 served first, then req2 with no idle gap beyond REQ-024.
REQ-037 Scenario: all four valid continuously -> grant order 0,1,2,3,0; every response index matches its grant.
REQ-038 Scenario: req1 a=0x7F800000 (inf), b=0x00000000 -> resp_z_o=0xFFC00000 (NaN) to requester 1.
REQ-039 Scenario: reset_i asserted in WAIT -> no resp_valid_o; busy_o=0 next cycle; next request served normally.
REQ-040 Scenario: spurious mul_done_strobe_i in IDLE -> no resp_valid_o, state unchanged.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types for the FP multiply arbiter.
// FP32 operand width and arbiter FSM states.
package fpu_pkg;

  localparam int FP32_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant.
// Search starts just after the last granted requester.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [IDX_W-1:0] sel;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel = IDX_W'((int'(last_grant) + 1 + i) % NUM_REQ);
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmul_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared FP32 multiplier.
// One operation outstanding; re-grant no earlier than after the response.
module fmul_arbiter
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                           clk,
  input  logic                           reset_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ-1:0][FP32_W-1:0] req_a_i,
  input  logic [NUM_REQ-1:0][FP32_W-1:0] req_b_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [NUM_REQ-1:0]             resp_valid_o,
  output logic [FP32_W-1:0]              resp_z_o,
  output logic                           busy_o,
  output logic [FP32_W-1:0]              mul_a_o,
  output logic [FP32_W-1:0]              mul_b_o,
  output logic                           mul_exec_strobe_o,
  input  logic [FP32_W-1:0]              mul_z_i,
  input  logic                           mul_done_strobe_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e               state_q;
  state_e               state_d;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     cur_idx;
  logic [IDX_W-1:0]     gnt_idx;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   resp_vec;
  logic                 take;
  logic                 finish;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req_valid_i),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gnt_idx = IDX_W'(i);
    end
  end

  // No grant in the response cycle keeps a single op in flight.
  assign req_ready_o = (state_q == IDLE && !(|resp_valid_o)) ? grant : '0;
  assign take        = |req_ready_o;
  assign finish      = (state_q == WAIT) && mul_done_strobe_i;
  assign resp_vec    = NUM_REQ'(1) << cur_idx;

  assign busy_o            = (state_q != IDLE);
  assign mul_exec_strobe_o = (state_q == ISSUE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mul_done_strobe_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q      <= IDLE;
      last_grant   <= IDX_W'(NUM_REQ - 1);
      cur_idx      <= '0;
      mul_a_o      <= '0;
      mul_b_o      <= '0;
      resp_z_o     <= '0;
      resp_valid_o <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_o <= finish ? resp_vec : '0;
      if (take) begin
        mul_a_o    <= req_a_i[gnt_idx];
        mul_b_o    <= req_b_i[gnt_idx];
        cur_idx    <= gnt_idx;
        last_grant <= gnt_idx;
      end
      if (finish) resp_z_o <= mul_z_i;
    end
  end

endmodule

// File: tb/tb_fmul_arbiter.sv
// Self-checking bench for fmul_arbiter with a mock multiplier
// and a transaction-level round-robin reference model.
module tb_fmul_arbiter;

  localparam int N = 4;

  logic             clk;
  logic             reset_i;
  logic [N-1:0]     rv;
  logic [N-1:0][31:0] ra;
  logic [N-1:0][31:0] rb;
  logic [N-1:0]     ready;
  logic [N-1:0]     rvalid;
  logic [31:0]      rz;
  logic             busy;
  logic [31:0]      ma;
  logic [31:0]      mb;
  logic             strobe;
  logic [31:0]      mz;
  logic             mdone;

  fmul_arbiter #(.NUM_REQ(N)) dut (
    .clk               (clk),
    .reset_i           (reset_i),
    .req_valid_i       (rv),
    .req_a_i           (ra),
    .req_b_i           (rb),
    .req_ready_o       (ready),
    .resp_valid_o      (rvalid),
    .resp_z_o          (rz),
    .busy_o            (busy),
    .mul_a_o           (ma),
    .mul_b_o           (mb),
    .mul_exec_strobe_o (strobe),
    .mul_z_i           (mz),
    .mul_done_strobe_i (mdone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // reference model: one outstanding op record
  bit          m_busy;
  bit          m_sd;
  int          m_idx;
  int          m_last;
  logic [31:0] m_a, m_b, m_z;
  logic [N-1:0] m_resp;
  int          m_ridx;

  // mock multiplier
  bit  mpend;
  int  mcnt;
  bit  force_done;

  int grants[$];
  int gcyc[$];
  int resps[$];
  int rcyc[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fmul_ref(logic [31:0] a, logic [31:0] b);
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (a == 32'h7F800000 && b == 32'h00000000) return 32'hFFC00000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h1234_5678;
  endfunction

  function automatic int rr_ref(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    int          g;
    logic [N-1:0] rexp;
    logic [N-1:0] nresp;
    if (force_done) begin
      mdone = 1'b1;
      mz    = $urandom;
    end else if (mpend && mcnt == 0) begin
      mdone = 1'b1;
      mz    = fmul_ref(m_a, m_b);
      mpend = 1'b0;
    end else begin
      mdone = 1'b0;
      if (mpend) mcnt--;
    end
    #1;
    g    = rr_ref(rv, m_last);
    rexp = (!m_busy && m_resp == '0 && g >= 0) ? N'(1 << g) : '0;
    chk("ready", ready, rexp);
    chk("busy", busy, m_busy);
    chk("strobe", strobe, m_sd);
    chk("resp_valid", rvalid, m_resp);
    chk("resp_z", rz, m_z);
    chk("mul_a", ma, m_a);
    chk("mul_b", mb, m_b);
    if (rexp != '0) begin
      grants.push_back(g);
      gcyc.push_back(cyc);
    end
    if (m_resp != '0) begin
      resps.push_back(m_ridx);
      rcyc.push_back(cyc);
    end
    if (m_sd) begin
      mpend = 1'b1;
      mcnt  = $urandom_range(0, 3);
    end
    if (reset_i) begin
      m_busy = 0; m_sd = 0; m_idx = 0;
      m_a = '0; m_b = '0; m_z = '0;
      m_resp = '0; m_last = N - 1;
      mpend = 1'b0;
    end else begin
      nresp = '0;
      if (!m_busy) begin
        if (rexp != '0) begin
          m_busy = 1; m_sd = 1;
          m_a = ra[g]; m_b = rb[g];
          m_idx = g; m_last = g;
        end
      end else if (m_sd) begin
        m_sd = 0;
      end else if (mdone) begin
        m_z    = mz;
        nresp  = N'(1 << m_idx);
        m_ridx = m_idx;
        m_busy = 0;
      end
      m_resp = nresp;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    rv      = '0;
    tick();
    tick();
    reset_i = 1'b0;
    grants.delete(); gcyc.delete();
    resps.delete();  rcyc.delete();
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (rvalid != '0) ok = 1'b1;
    end
  endtask

  bit ok;

  initial begin
    reset_i = 1'b1; rv = '0; ra = '0; rb = '0;
    mz = '0; mdone = 1'b0; force_done = 1'b0;
    mpend = 1'b0; mcnt = 0;
    m_busy = 0; m_sd = 0; m_idx = 0; m_ridx = 0; m_last = N - 1;
    m_a = '0; m_b = '0; m_z = '0; m_resp = '0;
    @(negedge clk);
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_rz", rz, 0);
    chk("rst_ma", ma, 0);

    // 2.0 * 3.0 from requester 0
    ra[0] = 32'h40000000; rb[0] = 32'h40400000; rv = 4'b0001;
    #1 chk("s35_ready", ready, 4'b0001);
    tick();
    rv = '0;
    chk("s35_strobe", strobe, 1);
    wait_resp(ok);
    chk("s35_timeout", ok, 1);
    chk("s35_rvalid", rvalid, 4'b0001);
    chk("s35_z", rz, 32'h40C00000);
    tick();
    chk("s35_pulse1", rvalid, 0);

    // req0 and req2 together
    do_reset();
    ra[0] = $urandom; rb[0] = $urandom;
    ra[2] = $urandom; rb[2] = $urandom;
    rv = 4'b0101;
    for (int i = 0; i < 20; i++) tick();
    rv = '0;
    chk("s36_ngr", (grants.size() >= 2), 1);
    if (grants.size() >= 2 && rcyc.size() >= 1) begin
      chk("s36_g0", grants[0], 0);
      chk("s36_g1", grants[1], 2);
      chk("s36_gap", gcyc[1] - rcyc[0], 1);
    end

    // all four continuously
    do_reset();
    rv = 4'b1111;
    for (int i = 0; i < 45; i++) begin
      for (int r = 0; r < N; r++) begin
        ra[r] = $urandom; rb[r] = $urandom;
      end
      tick();
    end
    rv = '0;
    chk("s37_ngr", (grants.size() >= 5), 1);
    if (grants.size() >= 5) begin
      chk("s37_o0", grants[0], 0);
      chk("s37_o1", grants[1], 1);
      chk("s37_o2", grants[2], 2);
      chk("s37_o3", grants[3], 3);
      chk("s37_o4", grants[4], 0);
    end
    for (int i = 0; i < resps.size() && i < grants.size(); i++)
      chk("s37_ridx", resps[i], grants[i]);

    // inf * 0 from requester 1
    do_reset();
    ra[1] = 32'h7F800000; rb[1] = 32'h00000000; rv = 4'b0010;
    tick();
    rv = '0;
    wait_resp(ok);
    chk("s38_timeout", ok, 1);
    chk("s38_rvalid", rvalid, 4'b0010);
    chk("s38_z", rz, 32'hFFC00000);

    // reset while waiting on the multiplier
    do_reset();
    ra[0] = $urandom; rb[0] = $urandom; rv = 4'b0001;
    tick();
    rv = '0;
    tick();
    chk("s39_inwait", {busy, strobe}, 2'b10);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("s39_noresp", rvalid, 0);
    chk("s39_idle", busy, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("s39_stillnone", rvalid, 0);
    ra[0] = $urandom; rb[0] = $urandom; rv = 4'b0001;
    tick();
    rv = '0;
    wait_resp(ok);
    chk("s39_timeout", ok, 1);
    chk("s39_rvalid", rvalid, 4'b0001);
    chk("s39_z", rz, fmul_ref(ma, mb));

    // spurious done in IDLE
    tick();
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    chk("s40_noresp", rvalid, 0);
    chk("s40_idle", busy, 0);
    tick();

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rv = N'($urandom);
      for (int r = 0; r < N; r++) begin
        ra[r] = $urandom; rb[r] = $urandom;
      end
      reset_i    = ($urandom_range(0, 79) == 0);
      force_done = !m_busy && ($urandom_range(0, 9) == 0);
      tick();
    end
    reset_i = 1'b0; force_done = 1'b0; rv = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
